// File: rtl/operand_loader_pkg.sv
// Shared types and defaults for the operand loader: FSM state encoding and
// default digit/operand widths.
package operand_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_A,
      S_LOAD_B,
      S_DONE,
      S_HOLD
   } loader_state_t;

   localparam int unsigned DIGIT_W_DEF = 4;
   localparam int unsigned WIDTH_DEF   = 8;

endpackage

// File: rtl/operand_loader_if.sv
// Digit-entry / control-unit bus of the operand loader.
// master = the loader itself, slave = front end plus control unit.
interface operand_loader_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIGIT_W = 4
);

   logic               loaddata;
   logic [DIGIT_W-1:0] digit_in;
   logic               digit_valid;
   logic               clear;
   logic               digit_ready;
   logic [WIDTH-1:0]   operand_a;
   logic [WIDTH-1:0]   operand_b;
   logic               inputdata_ready;
   logic               entering_b;

   modport master (
      input  loaddata, digit_in, digit_valid, clear,
      output digit_ready, operand_a, operand_b, inputdata_ready, entering_b
   );

   modport slave (
      output loaddata, digit_in, digit_valid, clear,
      input  digit_ready, operand_a, operand_b, inputdata_ready, entering_b
   );

endinterface

// File: rtl/operand_loader_digit_shift_reg.sv
// Operand register that shifts in one digit at the LSB end per enabled cycle,
// so digits entered MSB-first land in their natural positions.
module digit_shift_reg #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DIGIT_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clr,
   input  logic               shift_en,
   input  logic [DIGIT_W-1:0] din,
   output logic [WIDTH-1:0]   q
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {q[WIDTH-DIGIT_W-1:0], din};
      end
   end

endmodule

// File: rtl/operand_loader.sv
// Collects hex digits into two operands and hands them to the control unit
// through the loaddata / inputdata_ready handshake.
module operand_loader
   import operand_loader_pkg::*;
#(
   parameter int unsigned WIDTH   = WIDTH_DEF,
   parameter int unsigned DIGIT_W = DIGIT_W_DEF
) (
   input logic            clk,
   input logic            reset,
   operand_loader_if.master bus
);

   localparam int unsigned NDIG = WIDTH / DIGIT_W;
   localparam int unsigned CW   = $clog2(NDIG + 1);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   loader_state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          clr_ops, shift_a, shift_b;
   logic          ready, done, entb;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // Outputs decode the registered state only, so they change right after the edge.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      clr_ops = 1'b0;
      shift_a = 1'b0;
      shift_b = 1'b0;
      ready   = 1'b0;
      done    = 1'b0;
      entb    = 1'b0;
      case (state)
         S_IDLE, S_HOLD: begin
            entb = (state == S_HOLD);
            if (bus.loaddata) begin
               clr_ops = 1'b1;
               cnt_n   = '0;
               state_n = S_LOAD_A;
            end
         end
         S_LOAD_A, S_LOAD_B: begin
            ready = 1'b1;
            entb  = (state == S_LOAD_B);
            if (bus.clear) begin
               clr_ops = 1'b1;
               cnt_n   = '0;
               state_n = S_LOAD_A;
            end else if (!bus.loaddata) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end else if (bus.digit_valid) begin
               shift_a = (state == S_LOAD_A);
               shift_b = (state == S_LOAD_B);
               if (cnt == LAST) begin
                  cnt_n   = '0;
                  state_n = (state == S_LOAD_A) ? S_LOAD_B : S_DONE;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
         end
         S_DONE: begin
            done = 1'b1;
            entb = 1'b1;
            if (bus.clear) begin
               clr_ops = 1'b1;
               cnt_n   = '0;
               state_n = S_LOAD_A;
            end else if (!bus.loaddata) begin
               state_n = S_HOLD;
            end
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   digit_shift_reg #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) u_reg_a (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr_ops),
      .shift_en (shift_a),
      .din      (bus.digit_in),
      .q        (bus.operand_a)
   );

   digit_shift_reg #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) u_reg_b (
      .clk      (clk),
      .reset    (reset),
      .clr      (clr_ops),
      .shift_en (shift_b),
      .din      (bus.digit_in),
      .q        (bus.operand_b)
   );

   assign bus.digit_ready     = ready;
   assign bus.inputdata_ready = done;
   assign bus.entering_b      = entb;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader (WIDTH=8): entry, clear, abort, DONE
// freeze and a control-unit style release of loaddata.
module tb_operand_loader;

   logic clk;
   logic reset;
   int unsigned n_checks;
   int unsigned n_fail;

   operand_loader_if #(.WIDTH(8), .DIGIT_W(4)) bus ();

   operand_loader #(.WIDTH(8), .DIGIT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; presents the digit for exactly one rising edge.
   task automatic send_digit(input logic [3:0] d);
      bus.digit_in    = d;
      bus.digit_valid = 1'b1;
      @(negedge clk);
      bus.digit_valid = 1'b0;
   endtask

   task automatic check_ops(input string tag, input logic [7:0] a, input logic [7:0] b);
      check({tag, "_a"}, 32'(bus.operand_a), 32'(a));
      check({tag, "_b"}, 32'(bus.operand_b), 32'(b));
   endtask

   initial begin
      int unsigned waited;
      n_checks = 0;
      n_fail   = 0;

      // 1: reset dominates loaddata and digit_valid
      reset           = 1'b1;
      bus.loaddata    = 1'b1;
      bus.digit_valid = 1'b1;
      bus.digit_in    = 4'h5;
      bus.clear       = 1'b0;
      repeat (2) @(negedge clk);
      check_ops("rst", 8'h00, 8'h00);
      check("rst_ready", 32'(bus.digit_ready), 32'd0);
      check("rst_idr",   32'(bus.inputdata_ready), 32'd0);
      check("rst_entb",  32'(bus.entering_b), 32'd0);
      reset           = 1'b0;
      bus.digit_valid = 1'b0;
      @(negedge clk);
      check("t2_ready", 32'(bus.digit_ready), 32'd1);

      // 2: 3,A,0,7 -> A=0x3A, B=0x07
      send_digit(4'h3);
      check("t2_a1", 32'(bus.operand_a), 32'h03);
      send_digit(4'hA);
      check_ops("t2_afull", 8'h3A, 8'h00);
      check("t2_entb", 32'(bus.entering_b), 32'd1);
      send_digit(4'h0);
      check("t2_idr_early", 32'(bus.inputdata_ready), 32'd0);
      send_digit(4'h7);
      check_ops("t2_done", 8'h3A, 8'h07);
      check("t2_idr", 32'(bus.inputdata_ready), 32'd1);
      check("t2_ready_done", 32'(bus.digit_ready), 32'd0);
      bus.loaddata = 1'b0;
      @(negedge clk);
      check("t2_idr_hold", 32'(bus.inputdata_ready), 32'd0);
      check_ops("t2_hold", 8'h3A, 8'h07);

      // 3: clear in LOAD_B drops the simultaneous digit
      bus.loaddata = 1'b1;
      @(negedge clk);
      check_ops("t3_fresh", 8'h00, 8'h00);
      send_digit(4'h5);
      send_digit(4'h1);
      check("t3_entb_pre", 32'(bus.entering_b), 32'd1);
      bus.clear = 1'b1;
      send_digit(4'h9);
      bus.clear = 1'b0;
      check_ops("t3_clr", 8'h00, 8'h00);
      check("t3_entb", 32'(bus.entering_b), 32'd0);
      check("t3_ready", 32'(bus.digit_ready), 32'd1);
      send_digit(4'hF);
      check("t3_a1", 32'(bus.operand_a), 32'h0F);
      send_digit(4'hF);
      send_digit(4'h0);
      send_digit(4'h1);
      check_ops("t3_done", 8'hFF, 8'h01);
      check("t3_idr", 32'(bus.inputdata_ready), 32'd1);

      // 5: digit_valid ignored in DONE
      bus.digit_in    = 4'h8;
      bus.digit_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_ops("t5_frozen", 8'hFF, 8'h01);
         check("t5_ready", 32'(bus.digit_ready), 32'd0);
         check("t5_idr", 32'(bus.inputdata_ready), 32'd1);
      end
      bus.digit_valid = 1'b0;

      // 4: abort mid-B keeps partial values until the next loaddata rise
      bus.loaddata = 1'b0;
      @(negedge clk);
      bus.loaddata = 1'b1;
      @(negedge clk);
      send_digit(4'h1);
      send_digit(4'h2);
      send_digit(4'h3);
      bus.loaddata = 1'b0;
      @(negedge clk);
      check_ops("t4_abort", 8'h12, 8'h03);
      check("t4_ready", 32'(bus.digit_ready), 32'd0);
      check("t4_entb", 32'(bus.entering_b), 32'd0);
      check("t4_idr", 32'(bus.inputdata_ready), 32'd0);
      bus.loaddata = 1'b1;
      @(negedge clk);
      check_ops("t4_restart", 8'h00, 8'h00);
      check("t4_ready2", 32'(bus.digit_ready), 32'd1);

      // 6: control unit registers inputdata_ready and drops loaddata one edge later
      send_digit(4'h2);
      send_digit(4'h2);
      send_digit(4'h4);
      bus.digit_in    = 4'h4;
      bus.digit_valid = 1'b1;
      waited = 0;
      while (!bus.inputdata_ready && waited < 8) begin
         @(negedge clk);
         bus.digit_valid = 1'b0;
         waited++;
      end
      check("t6_wait", 32'(waited), 32'd1);
      check_ops("t6_ops", 8'h22, 8'h44);
      @(posedge clk);
      #1 bus.loaddata = 1'b0;
      @(negedge clk);
      check("t6_idr_still", 32'(bus.inputdata_ready), 32'd1);
      @(negedge clk);
      check("t6_idr_off", 32'(bus.inputdata_ready), 32'd0);
      check_ops("t6_held", 8'h22, 8'h44);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
